// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: default 800x480 panel timing, lock FSM
// state encoding and the blanking-inclusive total derivation.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 21;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Total period of one axis: active plus front porch, sync and back porch.
  function automatic int timing_total(input int act, input int fp,
                                      input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with raw (unregistered) active / sync decode.
// Sync outputs are "asserted" flags; polarity is applied by the consumer.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hs,
  output logic          o_vs
);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_wrap;
  logic          w_v_wrap;

  assign w_h_wrap = (int'(r_h_cnt) == H_TOTAL - 1);
  assign w_v_wrap = (int'(r_v_cnt) == V_TOTAL - 1);

  // h_cnt wraps every line; v_cnt advances on the h wrap and wraps with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_active = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
  assign o_hs     = (int'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                    (int'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign o_vs     = (int'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                    (int'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/axi4s_video_out.sv
// AXI4-Stream (RGB565, tuser=SOF, tlast=EOL) to parallel LCD video.
// A free-running raster drives the panel; the lock FSM aligns incoming
// frames to it and reports underflow / framing errors while locked.
module axi4s_video_out
  import video_timing_pkg::*;
#(
  parameter int   DATA_WIDTH = 16,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] vout_data,
  output logic                  vout_de,
  output logic                  vout_hs,
  output logic                  vout_vs,
  output logic                  locked,
  output logic                  underflow,
  output logic                  frame_err
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0]         w_h_cnt;
  logic [VW-1:0]         w_v_cnt;
  logic                  w_active, w_hs, w_vs;
  logic                  w_sof_pos, w_eol_pos, w_frame_last;
  logic                  w_sof_in;
  state_e                r_state, w_next;
  logic                  w_tready, w_show, w_uf, w_fe;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_de, r_hs, r_vs, r_uf, r_fe;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_active (w_active),
    .o_hs     (w_hs),
    .o_vs     (w_vs)
  );

  assign w_sof_pos    = (w_h_cnt == '0) && (w_v_cnt == '0);
  assign w_eol_pos    = (int'(w_h_cnt) == H_ACTIVE - 1);
  // Last cycle of the frame: the lock is taken here so that the state is
  // already LOCKED when the raster sits at (0,0) and the held SOF pixel is
  // consumed on the very first active pixel.
  assign w_frame_last = (int'(w_h_cnt) == H_TOTAL - 1) && (int'(w_v_cnt) == V_TOTAL - 1);
  assign w_sof_in     = s_axis_video_tvalid && s_axis_video_tuser;

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_SOF;
    else     r_state <= w_next;
  end

  // Next state, tready and per-pixel checks.
  always_comb begin
    w_next   = r_state;
    w_tready = 1'b0;
    w_show   = 1'b0;
    w_uf     = 1'b0;
    w_fe     = 1'b0;
    case (r_state)
      WAIT_SOF: begin
        // Drain stale pixels; hold an SOF until the raster comes round.
        w_tready = !w_sof_in;
        if (w_sof_in && w_frame_last) w_next = LOCKED;
      end
      LOCKED: begin
        w_tready = w_active;
        if (w_active) begin
          if (!s_axis_video_tvalid) begin
            w_uf   = 1'b1;
            w_next = WAIT_SOF;
          end else begin
            w_show = 1'b1;
            if ((s_axis_video_tuser != w_sof_pos) || (s_axis_video_tlast != w_eol_pos)) begin
              w_fe   = 1'b1;
              w_next = WAIT_SOF;
            end
          end
        end
      end
      default: w_next = WAIT_SOF;
    endcase
  end

  // Output registers: everything one cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_de   <= 1'b0;
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_uf   <= 1'b0;
      r_fe   <= 1'b0;
    end else begin
      r_data <= w_show ? s_axis_video_tdata : '0;
      r_de   <= w_active;
      r_hs   <= w_hs ? HS_POL : ~HS_POL;
      r_vs   <= w_vs ? VS_POL : ~VS_POL;
      r_uf   <= w_uf;
      r_fe   <= w_fe;
    end
  end

  assign s_axis_video_tready = w_tready;
  assign vout_data           = r_data;
  assign vout_de             = r_de;
  assign vout_hs             = r_hs;
  assign vout_vs             = r_vs;
  assign locked              = (r_state == LOCKED);
  assign underflow           = r_uf;
  assign frame_err           = r_fe;

endmodule

// File: tb/tb_axi4s_video_out.sv
// Directed bench for axi4s_video_out using an 8x5 raster (4x2 active).
module tb_axi4s_video_out;

  localparam int HT = 8;
  localparam int VT = 5;
  localparam int FT = HT * VT;

  logic        clk, rst;
  logic [15:0] tdata;
  logic        tvalid, tuser, tlast;
  logic        tready;
  logic [15:0] vout_data;
  logic        vout_de, vout_hs, vout_vs, locked, underflow, frame_err;

  int checks = 0;
  int errors = 0;
  int pos;                       // cycles since reset release = raster index
  int uf_cnt = 0, fe_cnt = 0, rdy_cnt = 0;

  axi4s_video_out #(
    .DATA_WIDTH(16),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_video_tdata  (tdata),
    .s_axis_video_tvalid (tvalid),
    .s_axis_video_tready (tready),
    .s_axis_video_tuser  (tuser),
    .s_axis_video_tlast  (tlast),
    .vout_data           (vout_data),
    .vout_de             (vout_de),
    .vout_hs             (vout_hs),
    .vout_vs             (vout_vs),
    .locked              (locked),
    .underflow           (underflow),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) pos <= 0;
    else     pos <= pos + 1;

  always @(negedge clk)
    if (!rst) begin
      if (underflow) uf_cnt++;
      if (frame_err) fe_cnt++;
      if (tready)    rdy_cnt++;
    end

  // Present one beat at edge+1, hold until accepted, then look at the output
  // one cycle later (edge+1). show=1 expects the pixel on the panel.
  task automatic push(input logic [15:0] d, input logic u, input logic l,
                      input logic show, output int waits);
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    waits = 0;
    #1;
    while (!tready && waits < 100) begin
      @(posedge clk); #2;
      waits++;
    end
    if (waits >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: pixel %h never accepted", d);
    end else begin
      @(posedge clk); #1;
      checks++;
      if (show) begin
        if (vout_data !== d || vout_de !== 1'b1) begin
          errors++;
          $display("FAIL shown_pixel: data %h de %b, expected %h de 1", vout_data, vout_de, d);
        end
      end else if (vout_data !== 16'h0) begin
        errors++;
        $display("FAIL drained_pixel: data %h, expected 0000", vout_data);
      end
    end
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((pos % FT) != p && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_pos: position %0d not reached", p);
    end
  endtask

  task automatic test_reset();
    int q;
    logic exp_de, exp_hs, exp_vs;
    clk = 0; rst = 0; tvalid = 0; tdata = 0; tuser = 0; tlast = 0;
    #1 rst = 1;
    #10;
    checks++;
    if (vout_data !== 16'h0 || vout_de !== 1'b0 || vout_hs !== 1'b1 || vout_vs !== 1'b1 ||
        locked !== 1'b0 || underflow !== 1'b0 || frame_err !== 1'b0 || tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: data %h de %b hs %b vs %b lk %b uf %b fe %b rdy %b, expected 0000 0 1 1 0 0 0 1",
               vout_data, vout_de, vout_hs, vout_vs, locked, underflow, frame_err, tready);
    end
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < FT; i++) begin
      @(posedge clk); #1;
      q      = pos - 1;            // raster position the outputs describe
      exp_de = ((q % HT) < 4) && ((q / HT) < 2);
      exp_hs = !((q % HT) == 5 || (q % HT) == 6);
      exp_vs = !((q / HT) == 3);
      checks++;
      if (vout_de !== exp_de) begin errors++; $display("FAIL idle_de pos %0d: got %b expected %b", q, vout_de, exp_de); end
      checks++;
      if (vout_hs !== exp_hs) begin errors++; $display("FAIL idle_hs pos %0d: got %b expected %b", q, vout_hs, exp_hs); end
      checks++;
      if (vout_vs !== exp_vs) begin errors++; $display("FAIL idle_vs pos %0d: got %b expected %b", q, vout_vs, exp_vs); end
      checks++;
      if (vout_data !== 16'h0 || locked !== 1'b0) begin
        errors++; $display("FAIL idle_data pos %0d: data %h locked %b, expected 0000 0", q, vout_data, locked);
      end
    end
  endtask

  task automatic test_lock();
    int w;
    wait_pos(10);                  // mid-frame: line 1, h=2
    for (int i = 0; i < 3; i++) begin
      push(16'hA0A0 + 16'(i), 1'b0, 1'b0, 1'b0, w);
      checks++;
      if (w !== 0) begin errors++; $display("FAIL drain_wait %0d: waited %0d expected 0", i, w); end
    end
    // SOF offered at position 13 is held until the raster reaches 0,0
    for (int k = 0; k < 8; k++) begin
      push(16'h0001 + 16'(k), (k == 0), ((k % 4) == 3), 1'b1, w);
      if (k == 0) begin
        checks++;
        if (w !== 27) begin errors++; $display("FAIL lock_latency: waited %0d expected 27", w); end
      end
    end
    checks++;
    if (locked !== 1'b1 || uf_cnt !== 0 || fe_cnt !== 0) begin
      errors++; $display("FAIL lock_state: locked %b uf %0d fe %0d, expected 1 0 0", locked, uf_cnt, fe_cnt);
    end
  endtask

  task automatic test_underflow();
    int w, uf0, fe0;
    uf0 = uf_cnt; fe0 = fe_cnt;
    for (int k = 0; k < 6; k++) push(16'h0021 + 16'(k), (k == 0), ((k % 4) == 3), 1'b1, w);
    tvalid = 1'b0;                 // starve line 1, h=2
    @(posedge clk); #1;
    checks++;
    if (vout_de !== 1'b1 || vout_data !== 16'h0 || underflow !== 1'b1 || locked !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL underflow_cycle: de %b data %h uf %b lk %b fe %b, expected 1 0000 1 0 0",
                         vout_de, vout_data, underflow, locked, frame_err);
    end
    @(posedge clk); #1;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse: got %b expected 0", underflow); end
    for (int k = 0; k < 8; k++) push(16'h0041 + 16'(k), (k == 0), ((k % 4) == 3), 1'b1, w);
    checks++;
    if (locked !== 1'b1 || uf_cnt - uf0 !== 1 || fe_cnt - fe0 !== 0) begin
      errors++; $display("FAIL underflow_relock: locked %b uf %0d fe %0d, expected 1 1 0", locked, uf_cnt - uf0, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int w, uf0, fe0;
    uf0 = uf_cnt; fe0 = fe_cnt;
    push(16'h0051, 1'b1, 1'b0, 1'b1, w);
    push(16'h0052, 1'b0, 1'b1, 1'b1, w);   // early tlast, still displayed
    checks++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL frame_err_cycle: fe %b lk %b uf %b, expected 1 0 0", frame_err, locked, underflow);
    end
    tvalid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL frame_err_pulse: fe %b lk %b, expected 0 0", frame_err, locked);
    end
    checks++;
    if (fe_cnt - fe0 !== 1 || uf_cnt - uf0 !== 0) begin
      errors++; $display("FAIL frame_err_count: fe %0d uf %0d, expected 1 0", fe_cnt - fe0, uf_cnt - uf0);
    end
  endtask

  task automatic test_back_to_back();
    int w, uf0, fe0, r_prev;
    uf0 = uf_cnt; fe0 = fe_cnt; r_prev = 0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        push(16'h0100 * 16'(f + 1) + 16'(k), (k == 0), ((k % 4) == 3), 1'b1, w);
        if (k == 0) begin
          if (f > 0) begin
            checks++;
            if (rdy_cnt - r_prev !== 8) begin
              errors++; $display("FAIL ready_per_frame %0d: got %0d expected 8", f, rdy_cnt - r_prev);
            end
          end
          r_prev = rdy_cnt;
        end
      end
    end
    checks++;
    if (uf_cnt - uf0 !== 0 || fe_cnt - fe0 !== 0 || locked !== 1'b1) begin
      errors++; $display("FAIL back_to_back: uf %0d fe %0d lk %b, expected 0 0 1", uf_cnt - uf0, fe_cnt - fe0, locked);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    push(16'h0601, 1'b1, 1'b0, 1'b1, w);
    push(16'h0602, 1'b0, 1'b0, 1'b1, w);
    #3 rst = 1'b1;                 // mid-cycle, between clock edges
    #1;
    checks++;
    if (vout_data !== 16'h0 || vout_de !== 1'b0 || vout_hs !== 1'b1 || vout_vs !== 1'b1 ||
        locked !== 1'b0 || underflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid: data %h de %b hs %b vs %b lk %b uf %b fe %b, expected 0000 0 1 1 0 0 0",
                         vout_data, vout_de, vout_hs, vout_vs, locked, underflow, frame_err);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push(16'h0701 + 16'(k), (k == 0), ((k % 4) == 3), 1'b1, w);
      if (k == 0) begin
        checks++;
        if (w !== FT) begin errors++; $display("FAIL relock_after_reset: waited %0d expected %0d", w, FT); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL reset_relock_state: locked %b expected 1", locked); end
    tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_underflow();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
